shift_add_mul: RTL and testbench

Multi-cycle unsigned shift-and-add multiplier for the RV32M datapath; sits directly downstream of `n_b_add` and owns one instance of it. Each cycle it drives `n_b_add` with the upper half of its partial-product accumulator and the multiplicand, then consumes the sum and carry-out. Operands enter and the 2N-bit product leaves over valid/ready handshakes, so the block slots between the issue stage and writeback.

---
 rtl/shift_add_mul.sv | 147 ++++++++++++++
 tb/tb_shift_add_mul.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mul.sv
// shift_add_mul: multi-cycle unsigned shift-and-add multiplier driving a single n_b_add each step.
// Optional macro SHIFT_ADD_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.

module n_b_add #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  logic [N:0] sum_s;

  assign sum_s = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  assign s     = sum_s[N-1:0];
  assign cout  = sum_s[N];
endmodule

module shift_add_mul #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p
);
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           out_valid_q, out_valid_d;

  logic [N-1:0]   add_b;
  logic [N-1:0]   add_s;
  logic           add_cout;
  logic [2*N-1:0] acc_step;
  logic [N-1:0]   b_shift;

  assign add_b = b_q[0] ? a_q : {N{1'b0}};

  n_b_add #(.N(N)) u_add (
    .a    (acc_q[2*N-1:N]),
    .b    (add_b),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_cout)
  );

  // The carry-out becomes the new MSB; the whole accumulator slides right one bit per step.
  assign acc_step = {add_cout, add_s, acc_q[N-1:1]};
  assign b_shift  = {1'b0, b_q[N-1:1]};

  // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = {(2*N){1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        acc_d = acc_step;
        b_d   = b_shift;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == LAST_CNT) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end
`ifdef SHIFT_ADD_MUL_EARLY_EXIT_EN
        else if (b_shift == {N{1'b0}}) begin
          // Skipped steps would only shift right, so apply them all at once.
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          acc_d       = acc_step >> (LAST_CNT - cnt_q);
        end
`endif
        else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= {N{1'b0}};
      b_q         <= {N{1'b0}};
      acc_q       <= {(2*N){1'b0}};
      cnt_q       <= {CW{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign p         = acc_q;
endmodule

// File: tb/tb_shift_add_mul.sv
// Scoreboard bench for shift_add_mul: driver pushes expected products, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_shift_add_mul;
  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] p;

  typedef struct {
    logic [2*N-1:0] prod;
    int             acc_edge;
    int             lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   hs_count = 0;
  int   hs_exp   = 0;
  bit   prev_ov  = 1'b0;

  shift_add_mul #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Cycle number (accept edge = cycle 0) in which out_valid should first rise.
  function automatic int exp_lat(input logic [N-1:0] bb);
`ifdef SHIFT_ADD_MUL_EARLY_EXIT_EN
    int m = 0;
    for (int i = 0; i < N; i++) if (bb[i]) m = i + 1;
    if (m < 1) m = 1;
    return m + 1;
`else
    return N + 1;
`endif
  endfunction

  // Monitor: compare the head of the scoreboard whenever a product is presented.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        check("product", p, sb[0].prod);
        check("in_ready_in_done", {63'd0, in_ready}, 64'd0);
        if (!prev_ov) check("latency", 64'(cyc - sb[0].acc_edge + 1), 64'(sb[0].lat));
        if (out_ready) begin
          void'(sb.pop_front());
          hs_count++;
        end
      end
    end
    prev_ov = out_valid;
  end

  task automatic issue(input logic [N-1:0] aa, input logic [N-1:0] bb,
                       input logic [2*N-1:0] pp, output int edge_no);
    int k = 0;
    exp_t e;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    edge_no = -1;
    if (!in_ready) begin
      check("in_ready_timeout", 64'd0, 64'd1);
    end else begin
      a        = aa;
      b        = bb;
      in_valid = 1'b1;
      edge_no  = cyc + 1;
      e.prod = pp; e.acc_edge = edge_no; e.lat = exp_lat(bb);
      sb.push_back(e);
      hs_exp++;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  int e0, e1;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_p", p, 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);

    issue(32'd3, 32'd5, 64'd15, e0);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, e0);
    issue(32'hDEADBEEF, 32'd0, 64'd0, e0);
    issue(32'hDEADBEEF, 32'd1, 64'h00000000DEADBEEF, e0);
    drain();

    // Back-to-back throughput with out_ready tied high.
    issue(32'd3, 32'd5, 64'd15, e0);
    issue(32'h0000FFFF, 32'h00010000, 64'h00000000FFFF0000, e1);
    check("throughput", 64'(e1 - e0), 64'(exp_lat(32'd5) + 1));
    drain();

    // Backpressure: hold out_ready low for 5 cycles after out_valid rises.
    out_ready = 1'b0;
    issue(32'd7, 32'd6, 64'd42, e0);
    begin
      int k = 0;
      while (!out_valid && k < 100) begin @(negedge clk); k++; end
      check("bp_out_valid_rise", {63'd0, out_valid}, 64'd1);
    end
    repeat (5) @(negedge clk);
    check("bp_held_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_after", {63'd0, in_ready}, 64'd1);
    check("bp_valid_drop", {63'd0, out_valid}, 64'd0);

    // in_valid during BUSY must be ignored.
    issue(32'd2, 32'd3, 64'd6, e0);
    a = 32'd9; b = 32'd9; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("single_handshake", 64'(hs_count), 64'(hs_exp));

    // Reset mid-operation at BUSY step 10 discards the result.
    issue(32'd5, 32'h80000001, 64'h0000000280000005, e0);
    repeat (9) @(negedge clk);
    sb.delete();
    hs_exp--;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_p", p, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    issue(32'd4, 32'd4, 64'd16, e0);
    drain();
    repeat (2) @(negedge clk);
    check("final_handshakes", 64'(hs_count), 64'(hs_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
